// File: rtl/moka_rv32i_sc_trace_buffer.sv
// rtl/moka_rv32i_sc_trace_buffer.sv - retirement-trace capture ring for the moka RV32I single-cycle core
module moka_rv32i_sc_trace_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] trig_pc,
    input  logic                  stop,
    input  logic                  retire,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [4:0]            rd,
    input  logic                  RegWrite,
    input  logic                  MemWrite,
    input  logic                  PCSrc,
    output logic [1:0]            state,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_pc,
    output logic [DATA_WIDTH-1:0] rd_instr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [4:0]            rd_rd,
    output logic [2:0]            rd_flags
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] trig_q;

    logic [DATA_WIDTH-1:0] mem_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data  [DEPTH];
    logic [4:0]            mem_rd    [DEPTH];
    logic [2:0]            mem_flags [DEPTH];

    logic full;
    logic trig_hit;
    logic push;
    logic pop;
    logic stop_on_full;

    assign full         = (count == CW'(DEPTH));
    assign trig_hit     = retire && (pc == trig_q);
    assign push         = !arm && (((state == S_ARMED) && trig_hit) ||
                                   ((state == S_CAPTURE) && retire));
    assign pop          = rd_valid && rd_ready;
    // Only continuous mode wraps; trigger mode continues as stop-on-full once fired.
    assign stop_on_full = (mode_q != 2'd0);

    assign rd_valid = (state == S_DONE) && (count != '0);
    assign rd_pc    = mem_pc[rd_ptr];
    assign rd_instr = mem_instr[rd_ptr];
    assign rd_data  = mem_data[rd_ptr];
    assign rd_rd    = mem_rd[rd_ptr];
    assign rd_flags = mem_flags[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mode_q   <= 2'd0;
            trig_q   <= '0;
        end else if (arm) begin
            count    <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mode_q   <= mode;
            trig_q   <= trig_pc;
            state    <= (mode == 2'd2) ? S_ARMED : S_CAPTURE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (full) begin
                    // Continuous mode: the oldest entry is overwritten, head moves past it.
                    rd_ptr   <= rd_ptr + 1'b1;
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
            case (state)
                S_ARMED: begin
                    if (stop) begin
                        state <= S_DONE;
                    end else if (trig_hit) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (stop || (push && stop_on_full && (count == CW'(DEPTH - 1)))) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (pop && (count == CW'(1))) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= instruction;
            mem_data[wr_ptr]  <= RegWrite ? WD3 : ALUResult;
            mem_rd[wr_ptr]    <= rd;
            mem_flags[wr_ptr] <= {PCSrc, MemWrite, RegWrite};
        end
    end

endmodule
